// File: rtl/ysyx_24120013_pkg.sv
// Shared types and constants for the ysyx_24120013 multi-cycle core controller.
package ysyx_24120013_pkg;

    typedef enum logic [2:0] {
        ST_FETCH_REQ  = 3'd0,
        ST_FETCH_WAIT = 3'd1,
        ST_EXEC       = 3'd2,
        ST_WB         = 3'd3,
        ST_HALT       = 3'd4
    } state_e;

    localparam logic [1:0] HALT_NONE     = 2'd0;
    localparam logic [1:0] HALT_EBREAK   = 2'd1;
    localparam logic [1:0] HALT_TIMEOUT  = 2'd2;
    localparam logic [1:0] HALT_MISALIGN = 2'd3;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_24120013_fetch_timer.sv
// Clearable, enable-gated saturating wait counter for the instruction fetch.
// tc_o flags that the next enabled cycle brings the count to all-ones.
module ysyx_24120013_fetch_timer
    import ysyx_24120013_pkg::*;
#(
    parameter int TIMEOUT_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + TIMEOUT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == (CNT_MAX - TIMEOUT_W'(1)));

endmodule

// File: rtl/ysyx_24120013_core_ctrl.sv
// Multi-cycle fetch/exec/writeback sequencer with valid/ready instruction fetch.
// Optional 64-bit perf counters are built when YSYX_24120013_PERF_EN is defined.
module ysyx_24120013_core_ctrl
    import ysyx_24120013_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              RADDR_W   = 5,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(DEFAULT_RESET_PC),
    parameter int              TIMEOUT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_rsp_valid,
    input  logic [31:0]        imem_rsp_data,
    output logic [31:0]        inst,
    input  logic               exu_wen,
    input  logic [RADDR_W-1:0] exu_waddr,
    input  logic [XLEN-1:0]    exu_wdata,
    input  logic               exu_jmp_en,
    input  logic [XLEN-1:0]    exu_jmp_target,
    input  logic               exu_ebreak,
    output logic               rf_wen,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]    rf_wdata,
    output logic [XLEN-1:0]    pc,
    output logic               halted,
    output logic [1:0]         halt_code
`ifdef YSYX_24120013_PERF_EN
    ,
    output logic [63:0]        perf_cycle,
    output logic [63:0]        perf_instret
`endif
);

    state_e               state_q, state_d;
    logic [XLEN-1:0]      pc_q, pc_d;
    logic [31:0]          inst_q, inst_d;
    logic                 req_valid_q, req_valid_d;
    logic                 rf_wen_q, rf_wen_d;
    logic [RADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]      rf_wdata_q, rf_wdata_d;
    logic                 jmp_taken_q, jmp_taken_d;
    logic [XLEN-1:0]      jmp_target_q, jmp_target_d;
    logic [1:0]           halt_code_q, halt_code_d;
    logic                 tmr_clr, tmr_en, tmr_tc;

    ysyx_24120013_fetch_timer #(
        .TIMEOUT_W(TIMEOUT_W)
    ) u_fetch_timer (
        .clk  (clk),
        .rst  (rst),
        .clr_i(tmr_clr),
        .en_i (tmr_en),
        .tc_o (tmr_tc)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        req_valid_d  = 1'b0;
        rf_wen_d     = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        jmp_taken_d  = jmp_taken_q;
        jmp_target_d = jmp_target_q;
        halt_code_d  = halt_code_q;
        tmr_clr      = 1'b0;
        tmr_en       = 1'b0;
        case (state_q)
            ST_FETCH_REQ: begin
                // The request is registered, so it first rises one edge after reset.
                req_valid_d = 1'b1;
                if (req_valid_q && imem_req_ready) begin
                    req_valid_d = 1'b0;
                    tmr_clr     = 1'b1;
                    state_d     = ST_FETCH_WAIT;
                end
            end
            ST_FETCH_WAIT: begin
                if (imem_rsp_valid) begin
                    inst_d  = imem_rsp_data;
                    state_d = ST_EXEC;
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_tc) begin
                        halt_code_d = HALT_TIMEOUT;
                        state_d     = ST_HALT;
                    end
                end
            end
            ST_EXEC: begin
                if (exu_ebreak) begin
                    halt_code_d = HALT_EBREAK;
                    state_d     = ST_HALT;
                end else if (exu_jmp_en && (exu_jmp_target[1:0] != 2'b00)) begin
                    halt_code_d = HALT_MISALIGN;
                    state_d     = ST_HALT;
                end else begin
                    rf_wen_d     = exu_wen && (exu_waddr != '0);
                    rf_waddr_d   = exu_waddr;
                    rf_wdata_d   = exu_wdata;
                    jmp_taken_d  = exu_jmp_en;
                    jmp_target_d = exu_jmp_target;
                    state_d      = ST_WB;
                end
            end
            ST_WB: begin
                pc_d        = jmp_taken_q ? jmp_target_q : (pc_q + XLEN'(4));
                req_valid_d = 1'b1;
                state_d     = ST_FETCH_REQ;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_FETCH_REQ;
            pc_q         <= RESET_PC;
            inst_q       <= NOP_INST;
            req_valid_q  <= 1'b0;
            rf_wen_q     <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            jmp_taken_q  <= 1'b0;
            jmp_target_q <= '0;
            halt_code_q  <= HALT_NONE;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            req_valid_q  <= req_valid_d;
            rf_wen_q     <= rf_wen_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            jmp_taken_q  <= jmp_taken_d;
            jmp_target_q <= jmp_target_d;
            halt_code_q  <= halt_code_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = pc_q;
    assign pc             = pc_q;
    assign inst           = inst_q;
    assign rf_wen         = rf_wen_q;
    assign rf_waddr       = rf_waddr_q;
    assign rf_wdata       = rf_wdata_q;
    assign halted         = (state_q == ST_HALT);
    assign halt_code      = halt_code_q;

`ifdef YSYX_24120013_PERF_EN
    logic [63:0] perf_cycle_q, perf_instret_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cycle_q   <= '0;
            perf_instret_q <= '0;
        end else begin
            if ((state_q != ST_HALT) && (perf_cycle_q != '1)) begin
                perf_cycle_q <= perf_cycle_q + 64'd1;
            end
            if ((state_q == ST_WB) && (perf_instret_q != '1)) begin
                perf_instret_q <= perf_instret_q + 64'd1;
            end
        end
    end

    assign perf_cycle   = perf_cycle_q;
    assign perf_instret = perf_instret_q;
`endif

endmodule

// File: tb/tb_ysyx_24120013_core_ctrl.sv
// Randomized bench for ysyx_24120013_core_ctrl; an instruction-level model
// predicts every output cycle by cycle from the fetch/exec/writeback timing rules.
module tb_ysyx_24120013_core_ctrl;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk, rst;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_addr, imem_rsp_data, inst;
    logic        exu_wen, exu_jmp_en, exu_ebreak;
    logic [4:0]  exu_waddr, rf_waddr;
    logic [31:0] exu_wdata, exu_jmp_target, rf_wdata, pc;
    logic        rf_wen, halted;
    logic [1:0]  halt_code;
`ifdef YSYX_24120013_PERF_EN
    logic [63:0] perf_cycle, perf_instret;
`endif

    ysyx_24120013_core_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .inst          (inst),
        .exu_wen       (exu_wen),
        .exu_waddr     (exu_waddr),
        .exu_wdata     (exu_wdata),
        .exu_jmp_en    (exu_jmp_en),
        .exu_jmp_target(exu_jmp_target),
        .exu_ebreak    (exu_ebreak),
        .rf_wen        (rf_wen),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .pc            (pc),
        .halted        (halted),
        .halt_code     (halt_code)
`ifdef YSYX_24120013_PERF_EN
        ,
        .perf_cycle    (perf_cycle),
        .perf_instret  (perf_instret)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural model and per-cycle expectations.
    logic [31:0] m_pc, m_inst;
    logic        m_halted;
    logic [1:0]  m_code;
    logic [63:0] m_instret;
    logic        exp_valid, exp_wen;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic        chk_en;
    int          n_vec, n_err, cyc_cnt, wen_cycle, wen_cnt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("imem_req_valid", imem_req_valid, exp_valid);
            chk("imem_addr", imem_addr, m_pc);
            chk("pc", pc, m_pc);
            chk("inst", inst, m_inst);
            chk("rf_wen", rf_wen, exp_wen);
            if (exp_wen) begin
                chk("rf_waddr", rf_waddr, exp_waddr);
                chk("rf_wdata", rf_wdata, exp_wdata);
            end
            chk("halted", halted, m_halted);
            chk("halt_code", halt_code, m_code);
`ifdef YSYX_24120013_PERF_EN
            chk("perf_instret", perf_instret, m_instret);
`endif
            if (rf_wen === 1'b1) begin
                wen_cycle = cyc_cnt;
                wen_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc_cnt++;
    endtask

    // Inputs the DUT must ignore in the current cycle are randomized.
    task automatic junk();
        imem_req_ready = 1'($urandom);
        imem_rsp_valid = 1'($urandom);
        imem_rsp_data  = $urandom;
        exu_wen        = 1'($urandom);
        exu_waddr      = 5'($urandom);
        exu_wdata      = $urandom;
        exu_jmp_en     = 1'($urandom);
        exu_jmp_target = $urandom;
        exu_ebreak     = 1'($urandom);
    endtask

    task automatic do_reset(input int pre);
        #(pre);
        rst    = 1'b0;
        chk_en = 1'b0;
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_pc", pc, RESET_PC);
        chk("rst_inst", inst, NOP);
        chk("rst_rf_wen", rf_wen, 0);
        chk("rst_rf_waddr", rf_waddr, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_halted", halted, 0);
        chk("rst_halt_code", halt_code, 0);
        m_pc = RESET_PC; m_inst = NOP; m_halted = 1'b0; m_code = 2'd0; m_instret = '0;
        exp_valid = 1'b0; exp_wen = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        junk();
        cyc_cnt = 0;
        chk_en  = 1'b1;
        tick();
    endtask

    task automatic halt_hold(input int n);
        for (int i = 0; i < n; i++) begin
            junk();
            exp_valid = 1'b0;
            tick();
        end
    endtask

    // rsp: wait cycle carrying the response (0 = never); abort: return at that wait cycle.
    task automatic run_instr(input int rdly, input int rsp, input logic [31:0] data,
                             input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                             input logic jmp, input logic [31:0] tgt, input logic ebrk,
                             input logic stale, input int abort);
        for (int i = 0; i <= rdly; i++) begin
            junk();
            imem_req_ready = (i == rdly);
            if (stale) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = 32'hDEAD_BEEF;
            end
            exp_valid = 1'b1;
            tick();
        end
        for (int i = 1; i <= 255; i++) begin
            if (abort != 0 && i == abort) return;
            junk();
            imem_rsp_valid = (i == rsp);
            imem_rsp_data  = data;
            exp_valid      = 1'b0;
            tick();
            if (i == rsp) break;
        end
        if (rsp < 1 || rsp > 255) begin
            m_halted = 1'b1; m_code = 2'd2;
            return;
        end
        m_inst = data;
        junk();
        exu_wen = wen; exu_waddr = wa; exu_wdata = wd;
        exu_jmp_en = jmp; exu_jmp_target = tgt; exu_ebreak = ebrk;
        tick();
        if (ebrk) begin
            m_halted = 1'b1; m_code = 2'd1;
            return;
        end
        if (jmp && tgt[1:0] != 2'b00) begin
            m_halted = 1'b1; m_code = 2'd3;
            return;
        end
        junk();
        exp_wen = wen && (wa != 5'd0); exp_waddr = wa; exp_wdata = wd;
        tick();
        exp_wen = 1'b0;
        m_pc = jmp ? tgt : m_pc + 32'd4;
        m_instret++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rdly, rsp, ab;
        logic jmp, eb;
        logic [31:0] tgt;
        logic [4:0] wa;
        n_vec = 0; n_err = 0; cyc_cnt = 0; wen_cycle = -1; wen_cnt = 0;
        rst = 1'b0; chk_en = 1'b0;
        exp_valid = 1'b0; exp_wen = 1'b0; exp_waddr = '0; exp_wdata = '0;
        m_pc = RESET_PC; m_inst = NOP; m_halted = 1'b0; m_code = 2'd0; m_instret = '0;
        junk();
        @(posedge clk); #1;
        do_reset(1);

        // addi x1,x0,5 with immediate ready and one-cycle response
        run_instr(0, 1, 32'h0050_0093, 1'b1, 5'd1, 32'd5, 1'b0, 32'd0, 1'b0, 1'b0, 0);
        chk("first_wb_cycle", wen_cycle, 4);
        chk("first_pc", pc, 32'h8000_0004);
        chk("first_inst", inst, 32'h0050_0093);
        // ready held low for 6 cycles; write to x0 is suppressed
        run_instr(6, 2, 32'h00A0_0113, 1'b1, 5'd0, 32'd7, 1'b0, 32'd0, 1'b0, 1'b0, 0);
        chk("x0_no_write", wen_cnt, 1);
        run_instr(0, 1, 32'h1000_006F, 1'b1, 5'd3, 32'd9, 1'b1, 32'h8000_0100, 1'b0, 1'b0, 0);
        chk("jump_addr", imem_addr, 32'h8000_0100);
        run_instr(1, 3, 32'h0000_006F, 1'b0, 5'd2, 32'd1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 0);
        run_instr(0, 1, NOP, 1'b0, 5'd2, 32'd1, 1'b0, 32'd0, 1'b0, 1'b0, 0);
        chk("pc_wrap", pc, 32'h0000_0000);
        run_instr(0, 1, 32'h0020_006F, 1'b1, 5'd5, 32'd3, 1'b1, 32'h8000_0102, 1'b0, 1'b0, 0);
        halt_hold(5);
        chk("misalign_halted", halted, 1);
        chk("misalign_code", halt_code, 3);
        chk("misalign_no_write", wen_cnt, 2);
        chk("misalign_pc", pc, 32'h0000_0000);
        do_reset(1);

        run_instr(0, 1, 32'h0010_0073, 1'b1, 5'd4, 32'd4, 1'b0, 32'd0, 1'b1, 1'b0, 0);
        halt_hold(20);
        chk("ebreak_code", halt_code, 1);
        chk("ebreak_pc", pc, 32'h8000_0000);
        chk("ebreak_req_valid", imem_req_valid, 0);
        do_reset(2);

        run_instr(0, 0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 0);
        halt_hold(3);
        chk("timeout_code", halt_code, 2);
        do_reset(1);

        // stale response during FETCH_REQ, then reset in the middle of FETCH_WAIT
        run_instr(0, 1, 32'h0050_0093, 1'b1, 5'd1, 32'd5, 1'b0, 32'd0, 1'b0, 1'b0, 0);
        run_instr(2, 5, 32'h1234_5678, 1'b1, 5'd1, 32'd5, 1'b0, 32'd0, 1'b0, 1'b1, 3);
        chk("stale_inst", inst, 32'h0050_0093);
        do_reset(2);

        for (int n = 0; n < 80; n++) begin
            rdly = ($urandom_range(0, 9) == 0) ? 7 : int'($urandom_range(0, 2));
            rsp  = ($urandom_range(0, 39) == 0) ? 0 : int'($urandom_range(1, 4));
            ab   = (rsp >= 2 && $urandom_range(0, 14) == 0) ? 1 : 0;
            wa   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            jmp  = ($urandom_range(0, 3) == 0);
            tgt  = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            eb   = ($urandom_range(0, 24) == 0);
            run_instr(rdly, rsp, $urandom, 1'($urandom), wa, $urandom, jmp, tgt, eb,
                      1'($urandom), ab);
            if (ab != 0) begin
                do_reset(int'($urandom_range(1, 2)));
            end else if (m_halted) begin
                halt_hold(int'($urandom_range(2, 8)));
                do_reset(int'($urandom_range(1, 2)));
            end
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_24120013_core_ctrl.md
Name: ysyx_24120013_core_ctrl

Overview:
- Parametrised multi-cycle sequencer; successor to the single-cycle top, which fetched one instruction per clock with no memory handshake.
- Owns the PC and fetches over a valid/ready instruction-memory interface. Holds the instruction stable for IDU/EXU and gates a one-cycle register-file write in writeback.
- Detects ebreak, fetch timeout and misaligned jump targets, and halts in each case.

Parameters:
- XLEN, 32, datapath/PC width.
- RADDR_W, 5, register address width.
- RESET_PC, 32'h8000_0000, PC value loaded at reset.
- TIMEOUT_W, 8, fetch-wait counter width; timeout fires at 2**TIMEOUT_W-1 cycles.

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  XLEN  fetch address (= pc)
- imem_rsp_valid  in  1  instruction data valid
- imem_rsp_data  in  32  instruction word
- inst  out  32  latched instruction to IDU
- exu_wen  in  1  EXU wants a register write
- exu_waddr  in  RADDR_W  destination register
- exu_wdata  in  XLEN  write data
- exu_jmp_en  in  1  redirect PC
- exu_jmp_target  in  XLEN  redirect target
- exu_ebreak  in  1  decoded instruction is ebreak
- rf_wen  out  1  register-file write enable (one-cycle pulse)
- rf_waddr  out  RADDR_W  register-file write address
- rf_wdata  out  XLEN  register-file write data
- pc  out  XLEN  current PC
- halted  out  1  core stopped
- halt_code  out  2  0 run, 1 ebreak, 2 fetch timeout, 3 misaligned target

Behaviour:
- Reset values while rst=0: state=FETCH_REQ, pc=RESET_PC, inst=32'h0000_0013 (nop), imem_req_valid=0, rf_wen=0, rf_waddr=0, rf_wdata=0, halted=0, halt_code=0, timeout counter=0.
- After release, imem_req_valid rises on the first clock edge.
- States: FETCH_REQ, FETCH_WAIT, EXEC, WB, HALT.
- FETCH_REQ:
  - imem_req_valid=1 and imem_addr=pc, both held stable until imem_req_ready=1.
  - On valid&ready, go to FETCH_WAIT and clear the counter.
- FETCH_WAIT:
  - imem_req_valid=0.
  - A response is legal at the earliest one cycle after acceptance.
  - On imem_rsp_valid, latch inst and go to EXEC.
  - Otherwise increment the counter. At all-ones, go to HALT with halt_code=2.
- imem_rsp_valid is ignored in every state other than FETCH_WAIT. Stale responses are dropped.
- EXEC: one cycle; the EXU inputs are combinational on inst and are sampled at the end of it.
  - exu_ebreak=1: go to HALT, halt_code=1; no write; pc unchanged.
  - exu_jmp_en=1 and exu_jmp_target[1:0]!=0: go to HALT, halt_code=3; no write.
  - Otherwise, register rf_wen/rf_waddr/rf_wdata and go to WB.
  - rf_wen is forced to 0 when exu_waddr==0.
- WB:
  - rf_wen is high for exactly this cycle.
  - pc <= exu_jmp_target (captured in EXEC) if a jump was taken, else pc+4, with XLEN wrap (all-ones-3 + 4 -> 0).
  - Next state is FETCH_REQ.
- Instruction latency is 4 cycles when memory is ready immediately and responds after 1 cycle.
- HALT: terminal state; halted=1, no requests, no writes, pc frozen. Only rst leaves it.
- Asynchronous reset mid-operation, in any state, returns immediately to the reset values. An outstanding request is abandoned.

Optional Feature:
- Macro YSYX_24120013_PERF_EN.
- Defined: adds outputs perf_cycle (64-bit, increments every cycle after reset while not halted) and perf_instret (64-bit, increments on each WB cycle). Both reset to 0 and saturate at all-ones.
- Undefined: ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package ysyx_24120013_pkg holds:
  - state enum (3-bit encoding);
  - halt code constants HALT_NONE/EBREAK/TIMEOUT/MISALIGN;
  - NOP_INST constant;
  - default RESET_PC.
- One natural sub-module, ysyx_24120013_fetch_timer: the clearable, enable-gated saturating wait counter with a terminal-count flag.

Test Plan:
- Reset release, memory ready=1 with response 1 cycle later returning 32'h00500093 (addi x1,x0,5), EXU wen=1 waddr=1 wdata=5 -> rf_wen pulses 1 cycle with waddr=1/wdata=5 at cycle 4; pc becomes 8000_0004.
- imem_req_ready held 0 for 6 cycles -> imem_req_valid stays 1 and imem_addr stays 8000_0000 throughout; accepted on cycle 7; no timeout.
- exu_jmp_en=1, target 8000_0100 -> next imem_addr=8000_0100; target 8000_0102 -> halted=1, halt_code=3, rf_wen never asserted.
- exu_ebreak=1 -> halted=1, halt_code=1; pc frozen and imem_req_valid=0 for the next 20 cycles.
- Request accepted, no response for 255 cycles -> halt_code=2. Separately, a response of 32'hDEADBEEF pulsed during FETCH_REQ -> inst unchanged.
- exu_waddr=0 with wen=1 -> rf_wen=0. Reset asserted during FETCH_WAIT -> outputs return to reset values in the same cycle, without a clock edge.
